// File: rtl/qpu_ifu_ifetch.sv
// QPU IFU fetch stage: PC generation, single outstanding fetch tracking and a 1-entry IR.
// Optional fetch counter output enabled by defining QPU_IFU_FETCH_CNT_EN.
module qpu_ifu_ifetch #(
    parameter int                 PC_SIZE    = 32,
    parameter int                 INSTR_SIZE = 32,
    parameter logic [PC_SIZE-1:0] RESET_PC   = {PC_SIZE{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  ifu_req_valid,
    input  logic                  ifu_req_ready,
    output logic [PC_SIZE-1:0]    ifu_req_pc,
    output logic                  ifu_req_seq,
    input  logic                  ifu_rsp_valid,
    output logic                  ifu_rsp_ready,
    input  logic [INSTR_SIZE-1:0] ifu_rsp_instr,
    output logic                  ifu_o_valid,
    input  logic                  ifu_o_ready,
    output logic [INSTR_SIZE-1:0] ifu_o_ir,
    output logic [PC_SIZE-1:0]    ifu_o_pc,
    input  logic                  pipe_flush_req,
    input  logic [PC_SIZE-1:0]    pipe_flush_pc,
    output logic                  pipe_flush_ack
`ifdef QPU_IFU_FETCH_CNT_EN
    ,
    output logic [31:0]           ifu_fetch_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DROP
    } state_e;

    state_e                  state_q, state_d;
    logic [PC_SIZE-1:0]      pc_nxt_q, pc_nxt_d;
    logic [PC_SIZE-1:0]      req_pc_q, req_pc_d;
    logic                    seq_q, seq_d;
    logic                    ir_valid_q, ir_valid_d;
    logic [INSTR_SIZE-1:0]   ir_q, ir_d;
    logic [PC_SIZE-1:0]      ir_pc_q, ir_pc_d;
    logic                    req_hsk, rsp_hsk, o_hsk, ir_fill;

    assign ifu_rsp_ready  = (state_q == ST_DROP) | ~ir_valid_q | ifu_o_ready;
    assign rsp_hsk        = ifu_rsp_valid & ifu_rsp_ready;
    // A new fetch may go out in the same cycle the outstanding one returns.
    assign ifu_req_valid  = rst_n & ~pipe_flush_req &
                            ((state_q == ST_IDLE) | ((state_q == ST_WAIT) & rsp_hsk));
    assign req_hsk        = ifu_req_valid & ifu_req_ready;
    assign ifu_req_pc     = pc_nxt_q;
    assign ifu_req_seq    = seq_q;
    assign ifu_o_valid    = ir_valid_q;
    assign ifu_o_ir       = ir_q;
    assign ifu_o_pc       = ir_pc_q;
    assign o_hsk          = ir_valid_q & ifu_o_ready;
    assign pipe_flush_ack = 1'b1;

    always_comb begin
        state_d    = state_q;
        pc_nxt_d   = pc_nxt_q;
        req_pc_d   = req_pc_q;
        seq_d      = seq_q;
        ir_valid_d = ir_valid_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_fill    = 1'b0;

        if (o_hsk) begin
            ir_valid_d = 1'b0;
        end

        if (pipe_flush_req) begin
            // Redirect: whatever is in flight becomes stale and the IR is emptied.
            pc_nxt_d   = pipe_flush_pc;
            seq_d      = 1'b0;
            ir_valid_d = 1'b0;
            case (state_q)
                ST_WAIT, ST_DROP: state_d = rsp_hsk ? ST_IDLE : ST_DROP;
                default:          state_d = ST_IDLE;
            endcase
        end else begin
            if (req_hsk) begin
                req_pc_d = pc_nxt_q;
                pc_nxt_d = pc_nxt_q + PC_SIZE'(4);
                seq_d    = 1'b1;
                state_d  = ST_WAIT;
            end
            case (state_q)
                ST_WAIT: begin
                    if (rsp_hsk) begin
                        ir_fill    = 1'b1;
                        ir_d       = ifu_rsp_instr;
                        ir_pc_d    = req_pc_q;
                        ir_valid_d = 1'b1;
                        if (!req_hsk) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (rsp_hsk) begin
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_nxt_q   <= RESET_PC;
            req_pc_q   <= {PC_SIZE{1'b0}};
            seq_q      <= 1'b0;
            ir_valid_q <= 1'b0;
            ir_q       <= {INSTR_SIZE{1'b0}};
            ir_pc_q    <= {PC_SIZE{1'b0}};
        end else begin
            state_q    <= state_d;
            pc_nxt_q   <= pc_nxt_d;
            req_pc_q   <= req_pc_d;
            seq_q      <= seq_d;
            ir_valid_q <= ir_valid_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
        end
    end

`ifdef QPU_IFU_FETCH_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;

    // Counts only responses that land in the IR; dropped ones are excluded.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        if (ir_fill) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign ifu_fetch_cnt = fetch_cnt_q;
`else
    logic unused_fill;
    assign unused_fill = ir_fill;
`endif

endmodule

// File: tb/tb_qpu_ifu_ifetch.sv
// Directed bench for qpu_ifu_ifetch with a 1-cycle ITCM responder and handshake logs.
module tb_qpu_ifu_ifetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_req_valid;
    logic        ifu_req_ready = 1'b0;
    logic [31:0] ifu_req_pc;
    logic        ifu_req_seq;
    logic        ifu_rsp_valid;
    logic        ifu_rsp_ready;
    logic [31:0] ifu_rsp_instr;
    logic        ifu_o_valid;
    logic        ifu_o_ready = 1'b0;
    logic [31:0] ifu_o_ir;
    logic [31:0] ifu_o_pc;
    logic        pipe_flush_req = 1'b0;
    logic [31:0] pipe_flush_pc = 32'h0;
    logic        pipe_flush_ack;
`ifdef QPU_IFU_FETCH_CNT_EN
    logic [31:0] ifu_fetch_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    qpu_ifu_ifetch #(.PC_SIZE(32), .INSTR_SIZE(32), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_req_pc     (ifu_req_pc),
        .ifu_req_seq    (ifu_req_seq),
        .ifu_rsp_valid  (ifu_rsp_valid),
        .ifu_rsp_ready  (ifu_rsp_ready),
        .ifu_rsp_instr  (ifu_rsp_instr),
        .ifu_o_valid    (ifu_o_valid),
        .ifu_o_ready    (ifu_o_ready),
        .ifu_o_ir       (ifu_o_ir),
        .ifu_o_pc       (ifu_o_pc),
        .pipe_flush_req (pipe_flush_req),
        .pipe_flush_pc  (pipe_flush_pc),
        .pipe_flush_ack (pipe_flush_ack)
`ifdef QPU_IFU_FETCH_CNT_EN
        ,
        .ifu_fetch_cnt  (ifu_fetch_cnt)
`endif
    );

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // ITCM model: answers one cycle after the request, holds until accepted.
    logic        itcm_en = 1'b0;
    logic        pend_q;
    logic [31:0] pend_pc_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= 1'b0;
            pend_pc_q <= 32'h0;
        end else begin
            if (ifu_rsp_valid && ifu_rsp_ready) pend_q <= 1'b0;
            if (ifu_req_valid && ifu_req_ready) begin
                pend_q    <= 1'b1;
                pend_pc_q <= ifu_req_pc;
            end
        end
    end

    assign ifu_rsp_valid = pend_q & itcm_en;
    assign ifu_rsp_instr = instr_of(pend_pc_q);

    // Handshake logs, sampled mid-cycle where all signals are settled.
    logic [31:0] req_pc_log[$], req_seq_log[$], o_pc_log[$], o_ir_log[$];
    int          req_cyc_log[$], o_cyc_log[$];
    logic [31:0] exp_req_pc[$], exp_req_seq[$], exp_o_pc[$];
    int          cyc = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n && ifu_req_valid && ifu_req_ready) begin
            req_pc_log.push_back(ifu_req_pc);
            req_seq_log.push_back({31'b0, ifu_req_seq});
            req_cyc_log.push_back(cyc);
            $display("req pc=%h seq=%0d cyc=%0d", ifu_req_pc, ifu_req_seq, cyc);
        end
        if (rst_n && ifu_o_valid && ifu_o_ready) begin
            o_pc_log.push_back(ifu_o_pc);
            o_ir_log.push_back(ifu_o_ir);
            o_cyc_log.push_back(cyc);
            $display("ir  pc=%h ir=%h cyc=%0d", ifu_o_pc, ifu_o_ir, cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_logs(input string tag);
        chk({tag, "_nreq"}, 64'(req_pc_log.size()), 64'(exp_req_pc.size()));
        chk({tag, "_nout"}, 64'(o_pc_log.size()), 64'(exp_o_pc.size()));
        for (int i = 0; i < req_pc_log.size() && i < exp_req_pc.size(); i++) begin
            chk($sformatf("%s_req_pc%0d", tag, i), 64'(req_pc_log[i]), 64'(exp_req_pc[i]));
            chk($sformatf("%s_req_seq%0d", tag, i), 64'(req_seq_log[i]), 64'(exp_req_seq[i]));
        end
        for (int i = 0; i < o_pc_log.size() && i < exp_o_pc.size(); i++) begin
            chk($sformatf("%s_o_pc%0d", tag, i), 64'(o_pc_log[i]), 64'(exp_o_pc[i]));
            chk($sformatf("%s_o_ir%0d", tag, i), 64'(o_ir_log[i]), 64'(instr_of(exp_o_pc[i])));
        end
        req_pc_log.delete(); req_seq_log.delete(); req_cyc_log.delete();
        o_pc_log.delete(); o_ir_log.delete(); o_cyc_log.delete();
        exp_req_pc.delete(); exp_req_seq.delete(); exp_o_pc.delete();
    endtask

    initial begin
        // Reset values
        tick();
        chk("rst_req_valid", 64'(ifu_req_valid), 64'd0);
        chk("rst_o_valid", 64'(ifu_o_valid), 64'd0);
        chk("rst_o_ir", 64'(ifu_o_ir), 64'd0);
        chk("rst_o_pc", 64'(ifu_o_pc), 64'd0);
        chk("flush_ack", 64'(pipe_flush_ack), 64'd1);
        rst_n = 1'b1;
        #1;
        chk("rel_req_valid", 64'(ifu_req_valid), 64'd1);
        chk("rel_req_pc", 64'(ifu_req_pc), 64'h0);
        chk("rel_req_seq", 64'(ifu_req_seq), 64'd0);

        // Streaming, one fetch per cycle
        itcm_en = 1'b1; ifu_req_ready = 1'b1; ifu_o_ready = 1'b1;
        tick(); tick(); tick();
        ifu_req_ready = 1'b0;
        tick(); tick(); tick();
        chk("stream_req_b2b", 64'(req_cyc_log.size() == 3 && req_cyc_log[2] - req_cyc_log[0] == 2), 64'd1);
        chk("stream_out_b2b", 64'(o_cyc_log.size() == 3 && o_cyc_log[2] - o_cyc_log[0] == 2), 64'd1);
        exp_req_pc = '{32'h0, 32'h4, 32'h8}; exp_req_seq = '{32'd0, 32'd1, 32'd1};
        exp_o_pc = '{32'h0, 32'h4, 32'h8};
        compare_logs("stream");

        // Asynchronous reset mid-operation, then IR backpressure
        rst_n = 1'b0;
        #1;
        chk("rst2_req_valid", 64'(ifu_req_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst2_req_pc", 64'(ifu_req_pc), 64'h0);
        ifu_req_ready = 1'b1; ifu_o_ready = 1'b0;
        tick(); tick();
        ifu_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_o_valid", 64'(ifu_o_valid), 64'd1);
            chk("bp_o_pc", 64'(ifu_o_pc), 64'h0);
            chk("bp_rsp_valid", 64'(ifu_rsp_valid), 64'd1);
            chk("bp_rsp_ready", 64'(ifu_rsp_ready), 64'd0);
            tick();
        end
        ifu_o_ready = 1'b1;
        tick();
        chk("bp_refill_pc", 64'(ifu_o_pc), 64'h4);
        chk("bp_refill_valid", 64'(ifu_o_valid), 64'd1);
        tick();
        chk("bp_drained", 64'(ifu_o_valid), 64'd0);
        exp_req_pc = '{32'h0, 32'h4}; exp_req_seq = '{32'd0, 32'd1};
        exp_o_pc = '{32'h0, 32'h4};
        compare_logs("bp");

        // Flush while fetch of 0x8 outstanding without a response
        itcm_en = 1'b0; ifu_req_ready = 1'b1;
        tick();
        ifu_req_ready = 1'b0;
        pipe_flush_req = 1'b1; pipe_flush_pc = 32'h100;
        #1;
        chk("fl1_req_valid", 64'(ifu_req_valid), 64'd0);
        tick();
        pipe_flush_req = 1'b0;
        #1;
        chk("fl1_drop_noreq", 64'(ifu_req_valid), 64'd0);
        chk("fl1_drop_rdy", 64'(ifu_rsp_ready), 64'd1);
        tick();
        chk("fl1_drop_hold", 64'(ifu_req_valid), 64'd0);
        itcm_en = 1'b1; ifu_req_ready = 1'b1;
        tick();
        chk("fl1_o_valid", 64'(ifu_o_valid), 64'd0);
        chk("fl1_req_pc", 64'(ifu_req_pc), 64'h100);
        chk("fl1_req_seq", 64'(ifu_req_seq), 64'd0);
        tick();
        ifu_req_ready = 1'b0;
        tick();
        chk("fl1_o_pc", 64'(ifu_o_pc), 64'h100);
        tick();
        exp_req_pc = '{32'h8, 32'h100}; exp_req_seq = '{32'd1, 32'd0};
        exp_o_pc = '{32'h100};
        compare_logs("fl1");

        // Flush in the response-handshake cycle with the IR full
        ifu_o_ready = 1'b0; ifu_req_ready = 1'b1;
        tick(); tick();
        ifu_req_ready = 1'b0;
        #1;
        chk("fl2_rsp_blocked", 64'(ifu_rsp_ready), 64'd0);
        ifu_o_ready = 1'b1; pipe_flush_req = 1'b1; pipe_flush_pc = 32'h200;
        #1;
        chk("fl2_rsp_hsk", 64'(ifu_rsp_valid & ifu_rsp_ready), 64'd1);
        chk("fl2_req_valid", 64'(ifu_req_valid), 64'd0);
        tick();
        pipe_flush_req = 1'b0;
        #1;
        chk("fl2_ir_cleared", 64'(ifu_o_valid), 64'd0);
        chk("fl2_req_valid_idle", 64'(ifu_req_valid), 64'd1);
        chk("fl2_req_pc", 64'(ifu_req_pc), 64'h200);
        chk("fl2_req_seq", 64'(ifu_req_seq), 64'd0);
        ifu_req_ready = 1'b1;
        tick();
        ifu_req_ready = 1'b0;
        tick();
        chk("fl2_o_pc", 64'(ifu_o_pc), 64'h200);
        tick();
        exp_req_pc = '{32'h104, 32'h108, 32'h200}; exp_req_seq = '{32'd1, 32'd1, 32'd0};
        exp_o_pc = '{32'h104, 32'h200};
        compare_logs("fl2");

        // PC wrap at the top of the address space
        pipe_flush_req = 1'b1; pipe_flush_pc = 32'hFFFF_FFFC;
        tick();
        pipe_flush_req = 1'b0; ifu_req_ready = 1'b1;
        tick(); tick();
        ifu_req_ready = 1'b0;
        tick(); tick();
        exp_req_pc = '{32'hFFFF_FFFC, 32'h0}; exp_req_seq = '{32'd0, 32'd1};
        exp_o_pc = '{32'hFFFF_FFFC, 32'h0};
        compare_logs("wrap");

`ifdef QPU_IFU_FETCH_CNT_EN
        // Captured since the mid-run reset: 0x0,0x4,0x100,0x104,0x200,0xFFFFFFFC,0x0
        chk("fetch_cnt", 64'(ifu_fetch_cnt), 64'd7);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
